// File: rtl/fft_out_reorder.sv
// Reorders one 16-point FFT frame from bit-reversed arrival order into natural bin order.
// Frames are buffered whole, then read out one bin per read request with one cycle of latency.
module fft_out_reorder #(
  parameter int unsigned WL = 16,
  parameter int unsigned N  = 16
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iCLR,
  input  logic          iEN,
  input  logic [WL-1:0] iDATA_re,
  input  logic [WL-1:0] iDATA_im,
  input  logic          iRD,
  output logic          oVALID,
  output logic [WL-1:0] oDATA_re,
  output logic [WL-1:0] oDATA_im,
  output logic [3:0]    oIDX,
  output logic          oFULL,
  output logic          oBUSY,
  output logic          oOVF
);

  typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

  state_e          state_q;
  logic [3:0]      wr_cnt_q;
  logic [3:0]      rd_cnt_q;
  logic [2*WL-1:0] mem_q [N];
  logic            wr_accept;

  function automatic logic [3:0] bitrev4(input logic [3:0] a);
    return {a[0], a[1], a[2], a[3]};
  endfunction

  // Writes only land while a frame is being collected; DRAIN drops them.
  assign wr_accept = iRSTn && !iCLR && iEN && (state_q != StDrain);

  // Buffer contents survive reset and clear; only the counters define frame validity.
  always_ff @(posedge iCLK) begin
    if (wr_accept) begin
      mem_q[bitrev4(wr_cnt_q)] <= {iDATA_re, iDATA_im};
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      state_q  <= StIdle;
      wr_cnt_q <= 4'd0;
      rd_cnt_q <= 4'd0;
      oVALID   <= 1'b0;
      oDATA_re <= '0;
      oDATA_im <= '0;
      oIDX     <= 4'd0;
      oOVF     <= 1'b0;
    end else if (iCLR) begin
      state_q  <= StIdle;
      wr_cnt_q <= 4'd0;
      rd_cnt_q <= 4'd0;
      oVALID   <= 1'b0;
      oOVF     <= 1'b0;
    end else begin
      oVALID <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (iEN) begin
            wr_cnt_q <= 4'd1;
            state_q  <= StFill;
          end
        end
        StFill: begin
          if (iEN) begin
            // Wraps to 0 after sample 15, ready for the next frame.
            wr_cnt_q <= wr_cnt_q + 4'd1;
            if (wr_cnt_q == 4'd15) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (iEN) begin
            oOVF <= 1'b1;
          end
          if (iRD) begin
            oVALID               <= 1'b1;
            {oDATA_re, oDATA_im} <= mem_q[rd_cnt_q];
            oIDX                 <= rd_cnt_q;
            rd_cnt_q             <= rd_cnt_q + 4'd1;
            if (rd_cnt_q == 4'd15) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oFULL = (state_q == StDrain);
  assign oBUSY = (state_q == StFill);

endmodule
